// File: rtl/mem_ctrl_pkg.sv
// Shared types and MEM control-field encodings for the data-memory sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_e;

  localparam int unsigned MEM_EN_BIT = 1;
  localparam int unsigned MEM_WR_BIT = 0;

  localparam logic [1:0] MEM_CTRL_STORE = 2'b11;
  localparam logic [1:0] MEM_CTRL_LOAD  = 2'b10;
  localparam logic [1:0] MEM_CTRL_NONE  = 2'b00;

  // A MEM-stage instruction needs the port only when it is valid and enabled.
  function automatic logic mem_is_access(input logic valid, input logic [1:0] ctrl);
    return valid & ctrl[MEM_EN_BIT];
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter for an outstanding request; expire is high in the last allowed cycle.
module mem_timeout_cnt #(
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per instruction,
// stalls the pipeline meanwhile and aborts with a sticky error on timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_m,
  input  logic [1:0]        mem_ctrl_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  input  logic              clear_err_i
);

  mem_state_e state, state_nx;
  logic       start;
  logic       launch;
  logic       cnt_en;
  logic       expire;
  logic       acc_done;
  logic       acc_tmo;

  assign start = mem_is_access(valid_m, mem_ctrl_m);

  mem_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (launch),
    .en     (cnt_en),
    .expire (expire)
  );

  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    launch   = 1'b0;
    cnt_en   = 1'b0;
    acc_done = 1'b0;
    acc_tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_o = start;
        if (start) begin
          launch   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        cnt_en  = 1'b1;
        // ack takes priority over an expiring counter in the same cycle
        if (dmem_ack) begin
          acc_done = 1'b1;
          state_nx = DONE;
        end else if (expire) begin
          acc_tmo  = 1'b1;
          state_nx = ERR;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      dmem_req      <= (state_nx == REQ);
      rdata_valid_o <= acc_done | acc_tmo;

      if (launch) begin
        dmem_we    <= mem_ctrl_m[MEM_WR_BIT];
        dmem_addr  <= addr_m;
        dmem_wdata <= wdata_m;
      end

      // Load data and the aborted-access zero are both written on the edge into
      // DONE/ERR so rdata_o is already settled while rdata_valid_o is high.
      if (acc_done && !dmem_we) begin
        rdata_o <= dmem_rdata;
      end else if (acc_tmo) begin
        rdata_o <= '0;
      end

      if (acc_tmo) begin
        err_o <= 1'b1;
      end else if (clear_err_i) begin
        err_o <= 1'b0;
      end
    end
  end

endmodule
